// File: rtl/fwd_hazard_ctrl_if.sv
// Decode-stage hazard bus: D-stage operand/write descriptors in, stall and forward selects out.
// The master side belongs to the decode stage, the slave side to fwd_hazard_ctrl.
interface fwd_hazard_ctrl_if #(
    parameter int TW    = 2,
    parameter int CNT_W = 32
);
    logic [4:0]       rs_d;
    logic [4:0]       rt_d;
    logic [TW-1:0]    tuse_rs_d;
    logic [TW-1:0]    tuse_rt_d;
    logic [4:0]       wdst_d;
    logic [TW-1:0]    tnew_d;
    logic [2:0]       wkind_d;
    logic             flush;
    logic             stall;
    logic [3:0]       fwd_rs_sel;
    logic [3:0]       fwd_rt_sel;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output rs_d, rt_d, tuse_rs_d, tuse_rt_d, wdst_d, tnew_d, wkind_d, flush,
        input  stall, fwd_rs_sel, fwd_rt_sel, stall_cnt
    );

    modport slave (
        input  rs_d, rt_d, tuse_rs_d, tuse_rt_d, wdst_d, tnew_d, wkind_d, flush,
        output stall, fwd_rs_sel, fwd_rt_sel, stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Tracks in-flight register writes in E/M/W and produces decode forward selects and stall.
// Optional macro FWD_HILO_EN: HI/LO results get dedicated codes 6/7 (M) and 8/9 (W).
module fwd_hazard_ctrl #(
    parameter int TW    = 2,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    fwd_hazard_ctrl_if.slave  bus
);
    typedef struct packed {
        logic          valid;
        logic [4:0]    dst;
        logic [TW-1:0] tnew;
        logic [2:0]    kind;
    } slot_t;

    typedef enum logic [1:0] {ST_E, ST_M, ST_W} stage_e;

    localparam logic [2:0] K_ALU  = 3'd0;
    localparam logic [2:0] K_LINK = 3'd1;
    localparam logic [2:0] K_HI   = 3'd2;
    localparam logic [2:0] K_LO   = 3'd3;
    localparam logic [2:0] K_LOAD = 3'd4;

    slot_t e_q, m_q, w_q;
    slot_t e_d, m_d, w_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [4:0] rs_res, rt_res;
    logic stall_int;

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

    // Returns {has_code, code}; a result kind with no mux input at this stage has no code.
    function automatic logic [4:0] fwd_code(input stage_e st, input logic [2:0] kind);
        logic [4:0] r;
        r = 5'd0;
        case (st)
            ST_E: if (kind == K_LINK) r = {1'b1, 4'd1};
            ST_M: case (kind)
                K_ALU:  r = {1'b1, 4'd2};
                K_LINK: r = {1'b1, 4'd3};
`ifdef FWD_HILO_EN
                K_HI:   r = {1'b1, 4'd6};
                K_LO:   r = {1'b1, 4'd7};
`else
                K_HI:   r = {1'b1, 4'd2};
                K_LO:   r = {1'b1, 4'd2};
`endif
                default: r = 5'd0;
            endcase
            ST_W: case (kind)
                K_ALU:  r = {1'b1, 4'd4};
                K_LOAD: r = {1'b1, 4'd4};
                K_LINK: r = {1'b1, 4'd5};
`ifdef FWD_HILO_EN
                K_HI:   r = {1'b1, 4'd8};
                K_LO:   r = {1'b1, 4'd9};
`else
                K_HI:   r = {1'b1, 4'd4};
                K_LO:   r = {1'b1, 4'd4};
`endif
                default: r = 5'd0;
            endcase
            default: r = 5'd0;
        endcase
        return r;
    endfunction

    // Returns {stall, sel} for one source operand; only the youngest matching slot decides.
    function automatic logic [4:0] resolve(input logic [4:0] src, input logic [TW-1:0] tuse,
                                           input slot_t e, input slot_t m, input slot_t w);
        slot_t      x;
        stage_e     st;
        logic       hit;
        logic [4:0] c;
        x   = '0;
        st  = ST_E;
        hit = 1'b1;
        if (src == 5'd0)                   hit = 1'b0;
        else if (e.valid && e.dst == src) begin x = e; st = ST_E; end
        else if (m.valid && m.dst == src) begin x = m; st = ST_M; end
        else if (w.valid && w.dst == src) begin x = w; st = ST_W; end
        else                               hit = 1'b0;
        if (!hit) return 5'd0;
        c = fwd_code(st, x.kind);
        if (x.tnew == '0 && c[4]) return {1'b0, c[3:0]};
        if (x.tnew > tuse)        return {1'b1, 4'd0};
        return 5'd0;
    endfunction

    always_comb begin
        rs_res    = resolve(bus.rs_d, bus.tuse_rs_d, e_q, m_q, w_q);
        rt_res    = resolve(bus.rt_d, bus.tuse_rt_d, e_q, m_q, w_q);
        stall_int = rs_res[4] | rt_res[4];
    end

    always_comb begin
        w_d      = m_q;
        w_d.tnew = sat_dec(m_q.tnew);
        m_d      = e_q;
        m_d.tnew = sat_dec(e_q.tnew);
        e_d      = '0;
        if (!stall_int && !bus.flush && bus.wdst_d != 5'd0)
            e_d = '{valid: 1'b1, dst: bus.wdst_d, tnew: bus.tnew_d, kind: bus.wkind_d};
        stall_cnt_d = stall_int ? stall_cnt_q + 1'b1 : stall_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q         <= '0;
            m_q         <= '0;
            w_q         <= '0;
            stall_cnt_q <= '0;
        end else begin
            e_q         <= e_d;
            m_q         <= m_d;
            w_q         <= w_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall      = stall_int;
    assign bus.fwd_rs_sel = rs_res[3:0];
    assign bus.fwd_rt_sel = rt_res[3:0];
    assign bus.stall_cnt  = stall_cnt_q;
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed scenarios then random traffic,
// all checked against an age-based model of in-flight writes.
module tb_fwd_hazard_ctrl;
    localparam int TW    = 2;
    localparam int CNT_W = 32;
`ifdef FWD_HILO_EN
    localparam bit HILO = 1'b1;
`else
    localparam bit HILO = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    fwd_hazard_ctrl_if #(.TW(TW), .CNT_W(CNT_W)) bus ();

    fwd_hazard_ctrl #(.TW(TW), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: index = cycles since the write entered E (0=E, 1=M, 2=W).
    int          m_valid [3];
    int          m_dst   [3];
    int          m_t0    [3];
    int          m_kind  [3];
    int unsigned m_cnt;
    int          exp_stall;

    function automatic int code_of(input int age, input int kind);
        case (age)
            0: return (kind == 1) ? 1 : -1;
            1: case (kind)
                0: return 2;
                1: return 3;
                2: return HILO ? 6 : 2;
                3: return HILO ? 7 : 2;
                default: return -1;
            endcase
            2: case (kind)
                0, 4: return 4;
                1: return 5;
                2: return HILO ? 8 : 4;
                3: return HILO ? 9 : 4;
                default: return -1;
            endcase
            default: return -1;
        endcase
    endfunction

    function automatic void predict(input int src, input int tuse, output int sel, output int stl);
        int cur;
        sel = 0;
        stl = 0;
        if (src == 0) return;
        for (int age = 0; age < 3; age++) begin
            if (m_valid[age] != 0 && m_dst[age] == src) begin
                cur = (m_t0[age] > age) ? m_t0[age] - age : 0;
                if (cur == 0 && code_of(age, m_kind[age]) >= 0) sel = code_of(age, m_kind[age]);
                else if (cur > tuse) stl = 1;
                return;
            end
        end
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 3; i++) begin
            m_valid[i] = 0; m_dst[i] = 0; m_t0[i] = 0; m_kind[i] = 0;
        end
        m_cnt = 0;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input int rs, input int rt, input int tu_rs, input int tu_rt,
                                 input int wdst, input int tnew, input int kind, input int fl);
        bus.rs_d      = 5'(rs);
        bus.rt_d      = 5'(rt);
        bus.tuse_rs_d = TW'(tu_rs);
        bus.tuse_rt_d = TW'(tu_rt);
        bus.wdst_d    = 5'(wdst);
        bus.tnew_d    = TW'(tnew);
        bus.wkind_d   = 3'(kind);
        bus.flush     = fl[0];
        #2;
    endtask

    task automatic checkOutput(input string tag);
        int s_rs, s_rt, st_rs, st_rt;
        predict(int'(bus.rs_d), int'(bus.tuse_rs_d), s_rs, st_rs);
        predict(int'(bus.rt_d), int'(bus.tuse_rt_d), s_rt, st_rt);
        exp_stall = st_rs | st_rt;
        check({tag, ".stall"}, 32'(bus.stall), 32'(exp_stall));
        check({tag, ".rs_sel"}, 32'(bus.fwd_rs_sel), 32'(s_rs));
        check({tag, ".rt_sel"}, 32'(bus.fwd_rt_sel), 32'(s_rt));
        check({tag, ".cnt"}, bus.stall_cnt, m_cnt);
    endtask

    // Advances the model across one rising edge using the stall predicted for this cycle.
    task automatic clockEdge();
        @(posedge clk);
        if (exp_stall != 0) m_cnt++;
        for (int i = 2; i > 0; i--) begin
            m_valid[i] = m_valid[i-1]; m_dst[i] = m_dst[i-1];
            m_t0[i] = m_t0[i-1]; m_kind[i] = m_kind[i-1];
        end
        if (exp_stall == 0 && bus.flush == 1'b0 && bus.wdst_d != 5'd0) begin
            m_valid[0] = 1; m_dst[0] = int'(bus.wdst_d);
            m_t0[0] = int'(bus.tnew_d); m_kind[0] = int'(bus.wkind_d);
        end else begin
            m_valid[0] = 0; m_dst[0] = 0; m_t0[0] = 0; m_kind[0] = 0;
        end
        #1;
    endtask

    task automatic cycle(input string tag, input int rs, input int rt, input int tu_rs, input int tu_rt,
                         input int wdst, input int tnew, input int kind, input int fl);
        applyStimulus(rs, rt, tu_rs, tu_rt, wdst, tnew, kind, fl);
        checkOutput(tag);
        clockEdge();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_stall = 0;
        modelReset();

        // Reset held with arbitrary inputs, across edges
        rst_n = 1'b0;
        applyStimulus(5, 5, 0, 0, 5, 3, 4, 0);
        checkOutput("rst");
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("rst_hold.stall", 32'(bus.stall), 32'd0);
            check("rst_hold.cnt", bus.stall_cnt, 32'd0);
        end
        applyStimulus(0, 0, 3, 3, 0, 0, 0, 0);
        rst_n = 1'b1;
        cycle("idle0", 1, 2, 0, 0, 0, 0, 0, 0);
        cycle("idle1", 3, 4, 0, 0, 0, 0, 0, 0);

        $display("[TB] ALU producer");
        cycle("alu_w", 0, 0, 3, 3, 5, 1, 0, 0);
        applyStimulus(5, 0, 0, 3, 0, 0, 0, 0); checkOutput("alu_e");
        check("alu_e.lit_stall", 32'(bus.stall), 32'd1); clockEdge();
        applyStimulus(5, 0, 0, 3, 0, 0, 0, 0); checkOutput("alu_m");
        check("alu_m.lit_sel", 32'(bus.fwd_rs_sel), 32'd2); clockEdge();
        applyStimulus(5, 0, 0, 3, 0, 0, 0, 0); checkOutput("alu_wb");
        check("alu_wb.lit_sel", 32'(bus.fwd_rs_sel), 32'd4); clockEdge();

        $display("[TB] load-use");
        cycle("ld_w", 0, 0, 3, 3, 8, 2, 4, 0);
        applyStimulus(0, 8, 3, 0, 0, 0, 0, 0); checkOutput("ld_e");
        check("ld_e.lit_stall", 32'(bus.stall), 32'd1); clockEdge();
        applyStimulus(0, 8, 3, 0, 0, 0, 0, 0); checkOutput("ld_m");
        check("ld_m.lit_stall", 32'(bus.stall), 32'd1); clockEdge();
        applyStimulus(0, 8, 3, 0, 0, 0, 0, 0); checkOutput("ld_wb");
        check("ld_wb.lit_sel", 32'(bus.fwd_rt_sel), 32'd4);
        check("ld_wb.lit_cnt", bus.stall_cnt, 32'd3); clockEdge();

        $display("[TB] link");
        cycle("jal_w", 0, 0, 3, 3, 31, 0, 1, 0);
        applyStimulus(31, 0, 0, 3, 0, 0, 0, 0); checkOutput("jal_e");
        check("jal_e.lit_sel", 32'(bus.fwd_rs_sel), 32'd1); clockEdge();
        applyStimulus(31, 0, 0, 3, 0, 0, 0, 0); checkOutput("jal_m");
        check("jal_m.lit_sel", 32'(bus.fwd_rs_sel), 32'd3); clockEdge();
        applyStimulus(31, 0, 0, 3, 0, 0, 0, 0); checkOutput("jal_wb");
        check("jal_wb.lit_sel", 32'(bus.fwd_rs_sel), 32'd5); clockEdge();

        $display("[TB] priority and $0");
        cycle("pri_w1", 0, 0, 3, 3, 9, 2, 4, 0);
        cycle("pri_w2", 0, 0, 3, 3, 9, 0, 1, 0);
        applyStimulus(9, 9, 0, 0, 0, 0, 0, 0); checkOutput("pri");
        check("pri.lit_sel", 32'(bus.fwd_rs_sel), 32'd1);
        check("pri.lit_stall", 32'(bus.stall), 32'd0); clockEdge();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0); checkOutput("zero");
        check("zero.lit_sel", 32'(bus.fwd_rs_sel), 32'd0); clockEdge();

        $display("[TB] HI read");
        cycle("hi_w", 0, 0, 3, 3, 3, 0, 2, 0);
        cycle("hi_e", 0, 3, 3, 3, 0, 0, 0, 0);
        applyStimulus(0, 3, 3, 3, 0, 0, 0, 0); checkOutput("hi_m");
        check("hi_m.lit_sel", 32'(bus.fwd_rt_sel), HILO ? 32'd6 : 32'd2); clockEdge();
        applyStimulus(0, 3, 3, 3, 0, 0, 0, 0); checkOutput("hi_wb");
        check("hi_wb.lit_sel", 32'(bus.fwd_rt_sel), HILO ? 32'd8 : 32'd4); clockEdge();

        $display("[TB] flush");
        cycle("fl_w", 0, 0, 3, 3, 3, 0, 2, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 3, 3, 3, 0, 0, 0, 0); checkOutput("fl");
            check("fl.lit_sel", 32'(bus.fwd_rt_sel), 32'd0); clockEdge();
        end

        $display("[TB] reset during stall");
        cycle("rs_w", 0, 0, 3, 3, 7, 3, 4, 0);
        applyStimulus(7, 0, 0, 3, 0, 0, 0, 0);
        check("rs_pre.lit_stall", 32'(bus.stall), 32'd1);
        rst_n = 1'b0;
        #1;
        modelReset();
        exp_stall = 0;
        check("rs_async.stall", 32'(bus.stall), 32'd0);
        check("rs_async.cnt", bus.stall_cnt, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        checkOutput("rs_after");
        clockEdge();

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            cycle("rnd", $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3),
                  $urandom_range(0, 4), ($urandom_range(0, 9) == 0) ? 1 : 0);
        end
        applyStimulus(0, 0, 3, 3, 0, 0, 0, 0);
        checkOutput("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
